// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or FWFT read mode,
// occupancy count, threshold flags and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]    count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_TH = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          ovf_q;
  logic          unf_q;
  logic          wr_acc;
  logic          rd_acc;

  // Flags judged on the registered count only.
  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Occupancy follows accepted traffic; both or neither holds it.
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + ONE;
      2'b01:   count_nxt = count_q - ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Storage array, not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count_q <= count_nxt;
      if (wr_en && full)  ovf_q <= 1'b1;
      if (rd_en && empty) unf_q <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; rd_en pops it.
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: popped word appears one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: vector table, directed
// corner sequences and a queue-based random model.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty;
  logic       almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic       f_wr_en = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic       f_rd_en = 1'b0;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty;
  logic       f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  sync_fifo_flex #(.FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf),
    .underflow(f_unf)
  );

  // {rd_data, count, full, empty, af, ae, ovf, unf, rv}
  function automatic logic [19:0] pk(
    logic [7:0] d, logic [4:0] c, logic f, logic e,
    logic af, logic ae, logic o, logic u, logic v);
    return {d, c, f, e, af, ae, o, u, v};
  endfunction

  function automatic logic [19:0] act();
    return pk(rd_data, count, full, empty, almost_full,
              almost_empty, overflow, underflow, rd_valid);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue plus the visible read register.
  logic [7:0] q[$];
  logic [7:0] m_rdat;
  logic       m_rv, m_ovf, m_unf;

  task automatic m_clear();
    q.delete();
    m_rdat = '0;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [19:0] m_pack();
    int n;
    n = q.size();
    return pk(m_rdat, 5'(n), n == 16, n == 0, n >= 14,
              n <= 2, m_ovf, m_unf, m_rv);
  endfunction

  task automatic m_apply(input logic w, input logic r,
                         input logic f, input logic [7:0] d);
    bit was_full, was_empty;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv = 1'b0;
      return;
    end
    was_full = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (w && was_full) m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    m_rv = r && !was_empty;
    if (m_rv) m_rdat = q.pop_front();
    if (w && !was_full) q.push_back(d);
  endtask

  task automatic cycle(input logic w, input logic r,
                       input logic f, input logic [7:0] d,
                       input string nm);
    wr_en = w;
    rd_en = r;
    flush = f;
    wr_data = d;
    m_apply(w, r, f, d);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    chk(nm, 32'(act()), 32'(m_pack()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m_clear();
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic       f;
    logic [7:0] d;
    logic [19:0] exp;
  } vec_t;

  vec_t tv[$];

  initial begin
    vec_t v;
    logic [7:0] dc;
    int n;

    // Fill 16, overflow, drain 16, underflow, flushes.
    for (int i = 0; i < 16; i++) begin
      n = i + 1;
      v = '{1'b1, 1'b0, 1'b0, 8'(i),
            pk(8'h00, 5'(n), n == 16, 1'b0, n >= 14,
               n <= 2, 1'b0, 1'b0, 1'b0)};
      tv.push_back(v);
    end
    v = '{1'b1, 1'b0, 1'b0, 8'hAA,
          pk(8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0)};
    tv.push_back(v);
    for (int j = 0; j < 16; j++) begin
      n = 15 - j;
      v = '{1'b0, 1'b1, 1'b0, 8'h00,
            pk(8'(j), 5'(n), 1'b0, n == 0, n >= 14,
               n <= 2, 1'b1, 1'b0, 1'b1)};
      tv.push_back(v);
    end
    v = '{1'b0, 1'b1, 1'b0, 8'h00,
          pk(8'h0F, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b1, 1'b1, 1'b0)};
    tv.push_back(v);
    v = '{1'b0, 1'b0, 1'b1, 8'h00,
          pk(8'h0F, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0)};
    tv.push_back(v);
    v = '{1'b1, 1'b1, 1'b1, 8'h77,
          pk(8'h0F, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0)};
    tv.push_back(v);

    // Reset state.
    m_clear();
    #12;
    chk("reset_async", 32'(act()),
        32'(pk(8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0)));
    chk("reset_fwft", {30'd0, f_rd_valid, f_empty},
        {30'd0, 1'b0, 1'b1});
    rst_n = 1'b1;
    #2;

    // Table vectors.
    for (int i = 0; i < tv.size(); i++) begin
      wr_en = tv[i].w;
      rd_en = tv[i].r;
      flush = tv[i].f;
      wr_data = tv[i].d;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
      chk($sformatf("vec%0d", i), 32'(act()),
          32'(tv[i].exp));
    end

    // Simultaneous read/write at count 5.
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "sim_fill");
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 1'b0, 8'(8'h20 + i), "sim_both");
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 1'b0, 8'h00, "sim_drain");

    // Full with both requests: write dropped, read taken.
    do_reset();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "full_fill");
    cycle(1'b1, 1'b1, 1'b0, 8'hEE, "full_both");
    chk("full_both_cnt", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++)
      cycle(1'b0, 1'b1, 1'b0, 8'h00, "full_drain");

    // Wrap-around at occupancy 3, 40 writes total.
    do_reset();
    dc = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, dc, "wrap_pre");
      dc++;
    end
    for (int i = 0; i < 37; i++) begin
      cycle(1'b1, 1'b1, 1'b0, dc, "wrap_run");
      dc++;
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b0, 8'h00, "wrap_post");

    // Async reset mid-burst at count 9.
    do_reset();
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 1'b0, 1'b0, 8'(i), "rst_fill");
    wr_en = 1'b1;
    wr_data = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    wr_en = 1'b0;
    #1;
    rst_n = 1'b1;
    m_clear();
    cycle(1'b1, 1'b0, 1'b0, 8'h33, "rst_first_wr");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "rst_first_rd");

    // FWFT: head word shows the cycle after its write.
    f_wr_en = 1'b1;
    f_wr_data = 8'h5A;
    step();
    f_wr_en = 1'b0;
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", 32'(f_rd_data), 32'h5A);
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    chk("fwft_empty", 32'(f_empty), 32'd1);
    chk("fwft_novalid", 32'(f_rd_valid), 32'd0);
    f_wr_en = 1'b1;
    f_wr_data = 8'hC1;
    step();
    f_wr_data = 8'hC2;
    step();
    f_wr_en = 1'b0;
    chk("fwft_head1", 32'(f_rd_data), 32'hC1);
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    chk("fwft_head2", 32'(f_rd_data), 32'hC2);
    chk("fwft_cnt", 32'(f_count), 32'd1);

    // Random traffic with shifting write bias.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int pw;
        logic w, r, f;
        pw = (ph == 0) ? 80 : (ph == 1) ? 20 :
             (ph == 2) ? 50 : 65;
        w = ($urandom_range(99) < pw);
        r = ($urandom_range(99) < (100 - pw));
        f = ($urandom_range(99) == 0);
        cycle(w, r, f, 8'($urandom), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
